// File: rtl/xor_bist_pkg.sv
// Shared definitions for the xor_bist block: FSM state encoding, vector
// set size, vector index type, error-count ceiling and small helpers.
package xor_bist_pkg;

    // Sweep controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Number of {a,b} stimulus vectors in one sweep.
    localparam int NUM_VECTORS = 4;

    // Index into the stimulus vector set; its two bits are {a,b}.
    typedef logic [1:0] vec_idx_t;

    // Mismatch counter ceiling.
    localparam logic [3:0] ERR_MAX = 4'd15;

    // Saturating increment of the mismatch counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        logic [3:0] result;
        if (value == ERR_MAX) begin
            result = ERR_MAX;
        end else begin
            result = value + 4'd1;
        end
        return result;
    endfunction

    // True for the states in which a sweep is in progress.
    function automatic logic is_active(input state_t st);
        logic result;
        case (st)
            ST_DRIVE:  result = 1'b1;
            ST_SETTLE: result = 1'b1;
            ST_CHECK:  result = 1'b1;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/xor_bist_vecgen.sv
// Stimulus vector generator for xor_bist. Holds the vector index counter.
// The 'vec' output is the index value that will be held after the current
// clock edge, so the parent can register a/b in step with its own state
// transition. 'last' flags that the currently held index is the final one.
module xor_bist_vecgen
    import xor_bist_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clear,
    input  logic     advance,
    output vec_idx_t vec,
    output logic     last
);

    vec_idx_t idx_r;
    vec_idx_t idx_nxt_s;

    // Next index: clear wins over advance; otherwise hold.
    always_comb begin
        idx_nxt_s = idx_r;
        if (clear) begin
            idx_nxt_s = 2'd0;
        end else if (advance) begin
            idx_nxt_s = idx_r + 2'd1;
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= 2'd0;
        end else begin
            idx_r <= idx_nxt_s;
        end
    end

    assign vec  = idx_nxt_s;
    assign last = (idx_r == vec_idx_t'(NUM_VECTORS - 1));

endmodule

// File: rtl/xor_bist.sv
// xor_bist: built-in self test for a 2-input XOR unit. One sweep applies
// {a,b} = 00, 01, 10, 11; each vector is driven for one cycle, allowed
// SETTLE_CYCLES cycles to settle, then the response c is compared against
// a^b. Mismatches are counted (saturating) and the first failing vector is
// recorded. done pulses for one cycle at the end of each sweep, and pass
// reports whether that sweep was clean.
//
// Optional feature: define XOR_BIST_LOOP_EN to let a start held high in
// DONE chain straight into another sweep, accumulating err_count and
// keeping first_fail across the chained sweeps. Without it every sweep
// returns to IDLE.
module xor_bist
    import xor_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [1:0] first_fail
);

    // Last value of the settle counter before moving on to CHECK.
    localparam logic [3:0] SETTLE_LAST =
        (SETTLE_CYCLES == 32'd0) ? 4'd0 : 4'(SETTLE_CYCLES - 32'd1);
    localparam logic SETTLE_SKIP = (SETTLE_CYCLES == 32'd0);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;

    logic       a_r;
    logic       b_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [3:0] err_r;
    logic [1:0] ff_r;

    logic       pass_nxt_s;
    logic [3:0] err_nxt_s;
    logic [1:0] ff_nxt_s;

    logic       clear_s;    // restart vector index at 0
    logic       advance_s;  // step to next vector
    logic       launch_s;   // fresh sweep from IDLE: also clears results
    logic       mismatch_s;

    vec_idx_t   vec_s;
    logic       last_s;

    xor_bist_vecgen u_vecgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear_s),
        .advance (advance_s),
        .vec     (vec_s),
        .last    (last_s)
    );

    // Sweep sequencing: next state and vector-generator controls.
    always_comb begin
        state_nxt_s = state_r;
        clear_s     = 1'b0;
        advance_s   = 1'b0;
        launch_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_DRIVE;
                    clear_s     = 1'b1;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (SETTLE_SKIP) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRIVE;
                    advance_s   = 1'b1;
                end
            end
            ST_DONE: begin
`ifdef XOR_BIST_LOOP_EN
                if (start) begin
                    // Chained sweep: restart the vectors, keep the results.
                    state_nxt_s = ST_DRIVE;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
`else
                state_nxt_s = ST_IDLE;
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Settle counter: counts cycles spent in SETTLE, zero elsewhere.
    always_comb begin
        cnt_nxt_s = 4'd0;
        if (state_r == ST_SETTLE) begin
            cnt_nxt_s = cnt_r + 4'd1;
        end else begin
            cnt_nxt_s = 4'd0;
        end
    end

    // Response checking and result bookkeeping.
    always_comb begin
        mismatch_s = (state_r == ST_CHECK) && (c != (a_r ^ b_r));
        err_nxt_s  = err_r;
        ff_nxt_s   = ff_r;
        pass_nxt_s = pass_r;
        if (launch_s) begin
            err_nxt_s  = 4'd0;
            ff_nxt_s   = 2'd0;
            pass_nxt_s = 1'b0;
        end else begin
            if (mismatch_s) begin
                err_nxt_s = sat_inc(err_r);
                if (err_r == 4'd0) begin
                    ff_nxt_s = {a_r, b_r};
                end else begin
                    ff_nxt_s = ff_r;
                end
            end else begin
                err_nxt_s = err_r;
                ff_nxt_s  = ff_r;
            end
            // pass is valid together with the done pulse.
            if (state_nxt_s == ST_DONE) begin
                pass_nxt_s = (err_nxt_s == 4'd0);
            end else begin
                pass_nxt_s = pass_r;
            end
        end
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            a_r     <= 1'b0;
            b_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= 4'd0;
            ff_r    <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (is_active(state_nxt_s)) begin
                a_r <= vec_s[1];
                b_r <= vec_s[0];
            end else begin
                a_r <= 1'b0;
                b_r <= 1'b0;
            end
            busy_r  <= is_active(state_nxt_s);
            done_r  <= (state_nxt_s == ST_DONE);
            pass_r  <= pass_nxt_s;
            err_r   <= err_nxt_s;
            ff_r    <= ff_nxt_s;
        end
    end

    assign a          = a_r;
    assign b          = b_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_count  = err_r;
    assign first_fail = ff_r;

endmodule

// File: tb/tb_xor_bist.sv
// Self-checking bench for xor_bist. Three instances with SETTLE_CYCLES of
// 0, 1 and 3 each drive a behavioural XOR unit described by a 4-entry truth
// table (c = table[{a,b}]); a correct unit is 4'b0110. Expected results are
// derived from the truth table by counting vectors whose response differs
// from a^b. Build with XOR_BIST_LOOP_EN defined to exercise chained sweeps.
module tb_xor_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] a_v;
    logic [2:0] b_v;
    logic [2:0] c_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] pass_v;
    logic [3:0] err_v [3];
    logic [1:0] ff_v  [3];
    logic [3:0] tt_v  [3];

    int checks = 0;
    int errors = 0;
    int lat [3] = '{2, 3, 5};

    always #5 clk = ~clk;

    // Behavioural XOR units under test, one per instance.
    always_comb begin
        c_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            c_v[i] = tt_v[i][{a_v[i], b_v[i]}];
        end
    end

    xor_bist #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .c(c_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .first_fail(ff_v[0]));

    xor_bist #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .c(c_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_v[1]), .first_fail(ff_v[1]));

    xor_bist #(.SETTLE_CYCLES(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .c(c_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(err_v[2]), .first_fail(ff_v[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: mismatch count and first failing vector of one sweep.
    function automatic void model(input logic [3:0] tt, output logic [3:0] e, output logic [1:0] f);
        logic [1:0] vb;
        e = 4'd0;
        f = 2'd0;
        for (int v = 0; v < 4; v++) begin
            vb = 2'(v);
            if (tt[v] != (vb[1] ^ vb[0])) begin
                if (e == 4'd0) f = vb;
                e = e + 4'd1;
            end
        end
    endfunction

    // One full sweep on instance d; called at a negedge with d idle.
    task automatic run_sweep(input int d, input logic [3:0] tt);
        int         per;
        logic [3:0] exp_err;
        logic [1:0] exp_ff;
        per = lat[d];
        model(tt, exp_err, exp_ff);
        tt_v[d]    = tt;
        start_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[d] = 1'b0;
        check("clr_err", err_v[d], 32'd0);
        check("clr_ff", ff_v[d], 32'd0);
        check("clr_pass", pass_v[d], 32'd0);
        for (int k = 0; k < 4 * per; k++) begin
            check("busy", busy_v[d], 32'd1);
            check("done_early", done_v[d], 32'd0);
            check("ab_seq", {a_v[d], b_v[d]}, 32'(k / per));
            @(negedge clk);
        end
        check("done_cycle", done_v[d], 32'd1);
        check("busy_done", busy_v[d], 32'd0);
        check("ab_done", {a_v[d], b_v[d]}, 32'd0);
        check("err_count", err_v[d], 32'(exp_err));
        check("first_fail", ff_v[d], 32'(exp_ff));
        @(negedge clk);
        check("done_pulse", done_v[d], 32'd0);
        check("busy_idle", busy_v[d], 32'd0);
        check("pass", pass_v[d], 32'(exp_err == 4'd0));
        check("err_hold", err_v[d], 32'(exp_err));
    endtask

    // Start held high on instance 1 across three sweeps with c stuck at 1.
    task automatic hold_start_test();
        int dn   = 0;
        int idle = 0;
        int cyc  = 0;
        int exp_idle;
        int sweep_err;
        tt_v[1]    = 4'b1111;
        start_v[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
`ifdef XOR_BIST_LOOP_EN
        exp_idle = 0;
`else
        exp_idle = 2;
`endif
        while (dn < 3 && cyc < 300) begin
            if (done_v[1]) begin
                dn++;
`ifdef XOR_BIST_LOOP_EN
                sweep_err = 2 * dn;
`else
                sweep_err = 2;
`endif
                check("hold_err", err_v[1], 32'(sweep_err));
                check("hold_ff", ff_v[1], 32'd0);
                if (dn == 3) start_v[1] = 1'b0;
            end else if (!busy_v[1]) begin
                idle++;
            end
            cyc++;
            @(negedge clk);
        end
        start_v[1] = 1'b0;
        check("hold_dones", dn, 32'd3);
        check("hold_idle", idle, 32'(exp_idle));
        check("hold_pass", pass_v[1], 32'd0);
        check("hold_stop", busy_v[1], 32'd0);
    endtask

    // Reset in the middle of a sweep on instance 2.
    task automatic reset_abort_test();
        int per;
        int seen_done = 0;
        int seen_busy = 0;
        per        = lat[2];
        tt_v[2]    = 4'b0000;
        start_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[2] = 1'b0;
        for (int k = 0; k < 2 * per; k++) @(negedge clk);
        check("abort_vec", {a_v[2], b_v[2]}, 32'd2);
        check("abort_err_pre", err_v[2], 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_ab", {a_v[2], b_v[2]}, 32'd0);
        check("rst_busy", busy_v[2], 32'd0);
        check("rst_done", done_v[2], 32'd0);
        check("rst_err", err_v[2], 32'd0);
        check("rst_ff", ff_v[2], 32'd0);
        check("rst_pass", pass_v[2], 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4 * per + 4; k++) begin
            if (done_v[2]) seen_done++;
            if (busy_v[2]) seen_busy++;
            @(negedge clk);
        end
        check("abort_no_done", seen_done, 32'd0);
        check("abort_waits", seen_busy, 32'd0);
        run_sweep(2, 4'b0110);
    endtask

    initial begin
        logic [3:0] tt;
        int         d;
        rst_n   = 1'b0;
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) tt_v[i] = 4'b0110;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_outs", {a_v[i], b_v[i], busy_v[i], done_v[i], pass_v[i], err_v[i], ff_v[i]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(1, 4'b0110);   // correct unit
        run_sweep(1, 4'b0000);   // c stuck at 0
        run_sweep(1, 4'b1110);   // c = a|b
        run_sweep(0, 4'b0110);   // no settle cycles
        run_sweep(2, 4'b0110);   // three settle cycles
        reset_abort_test();
        hold_start_test();

        for (int n = 0; n < 12; n++) begin
            d  = int'($urandom_range(0, 2));
            tt = 4'($urandom_range(0, 15));
            run_sweep(d, tt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
